cook_countdown: RTL

//  Downstream of the time-setting stage: latches the set time (min/sec) on a start request and counts down
//  at 1 Hz to 00:00. Drives the turntable/magnetron enable and a one-cycle done pulse, then sounds the buzzer.

---
 rtl/microwave_pkg.sv | 20 ++
 rtl/tick_gen.sv | 30 +++
 rtl/cook_countdown.sv | 137 +++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller: FSM encodings, time width and
// the clamp applied to set-time values.
package microwave_pkg;

   localparam int TIME_W = 6;
   localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_BEEP  = 2'd3
   } state_t;

   // The setting stage can present up to 63; anything above 59 saturates.
   function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
      return (v > MAX_SEC) ? MAX_SEC : v;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick on every TICK_CYCLES-th enabled clock.
// The tick is decoded from the count so the consumer acts on the wrapping edge itself.
module tick_gen #(
   parameter int TICK_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cook_countdown.sv
// Cook timer: latches the set time on start, counts down at 1 Hz, pulses done and beeps.
// Optional door interlock is enabled by defining DOOR_INTERLOCK_EN.
module cook_countdown
   import microwave_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_CYCLES = CLK_FREQ_HZ,
   parameter int BEEP_SEC    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TIME_W-1:0] i_set_min,
   input  logic [TIME_W-1:0] i_set_sec,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_cancel,
   input  logic              i_door_open,
   output logic [TIME_W-1:0] o_min,
   output logic [TIME_W-1:0] o_sec,
   output logic              o_motor_en,
   output logic              o_done,
   output logic              o_beep,
   output logic [1:0]        o_state
);

   localparam int BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
   localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);

   state_t            state, next_state;
   logic [TIME_W-1:0] set_min_c, set_sec_c, min_n, sec_n;
   logic [BEEP_W-1:0] beep_cnt, beep_cnt_n;
   logic              set_nonzero, start_ok, door_block, done_n;
   logic              tick, tick_en, tick_clr;

   assign set_min_c   = clamp_time(i_set_min);
   assign set_sec_c   = clamp_time(i_set_sec);
   assign set_nonzero = (set_min_c != '0) || (set_sec_c != '0);

`ifdef DOOR_INTERLOCK_EN
   assign start_ok   = i_start && !i_door_open;
   assign door_block = i_door_open;
`else
   logic unused_door;
   assign unused_door = i_door_open;
   assign start_ok    = i_start;
   assign door_block  = 1'b0;
`endif

   // Prescaler is parked at zero in IDLE, holds in PAUSE, and keeps running in BEEP.
   assign tick_en  = (state == ST_RUN) || (state == ST_BEEP);
   assign tick_clr = (state == ST_IDLE);

   tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      next_state = state;
      min_n      = o_min;
      sec_n      = o_sec;
      beep_cnt_n = beep_cnt;
      done_n     = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (!i_cancel && !i_pause && start_ok && set_nonzero) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (i_cancel) begin
               next_state = ST_IDLE;
            end else if (i_pause || door_block) begin
               next_state = ST_PAUSE;
            end else if (tick) begin
               if (o_sec != '0) begin
                  sec_n = o_sec - TIME_W'(1);
               end else if (o_min != '0) begin
                  min_n = o_min - TIME_W'(1);
                  sec_n = MAX_SEC;
               end
               if (min_n == '0 && sec_n == '0) begin
                  next_state = ST_BEEP;
                  done_n     = 1'b1;
                  beep_cnt_n = '0;
               end
            end
         end
         ST_PAUSE: begin
            if (i_cancel)                  next_state = ST_IDLE;
            else if (!i_pause && start_ok) next_state = ST_RUN;
         end
         ST_BEEP: begin
            if (i_cancel || i_start) begin
               next_state = ST_IDLE;
            end else if (tick) begin
               if (beep_cnt == BEEP_LAST) next_state = ST_IDLE;
               else                       beep_cnt_n = beep_cnt + BEEP_W'(1);
            end
         end
         default: next_state = ST_IDLE;
      endcase

      // Any cycle spent in IDLE, including the entry edge, shows the set time.
      if (next_state == ST_IDLE) begin
         min_n = set_min_c;
         sec_n = set_sec_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         o_min      <= '0;
         o_sec      <= '0;
         o_motor_en <= 1'b0;
         o_done     <= 1'b0;
         o_beep     <= 1'b0;
         beep_cnt   <= '0;
      end else begin
         state      <= next_state;
         o_min      <= min_n;
         o_sec      <= sec_n;
         o_motor_en <= (next_state == ST_RUN);
         o_done     <= done_n;
         o_beep     <= (next_state == ST_BEEP);
         beep_cnt   <= beep_cnt_n;
      end
   end

   assign o_state = state;

endmodule
